bsg_murn_endpoint: RTL and testbench

Block-side endpoint of the murn valid/retry switch link. It is the far end of the FSB-to-greendroid converter: it terminates one switch port and presents plain valid/ready and valid/yumi ring-packet interfaces to a local device core (tile emulator, test client, FPGA-side greendroid model). It buffers inbound packets and issues registered retries when full. It holds outbound packets until the switch stops retrying them.

---
 rtl/bsg_murn_endpoint.sv | 119 +++++++++++
 tb/tb_bsg_murn_endpoint.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/bsg_murn_endpoint.sv
// bsg_murn_endpoint: block-side terminus of a murn valid/retry switch port.
// Inbound packets are buffered in an rx FIFO, and a registered retry is
// returned when that FIFO is full. Outbound packets stay in a tx FIFO until
// the switch accepts them, which it signals by not retrying in the cycle
// after a send.
module bsg_murn_endpoint #(
  parameter int unsigned ring_width_p = 80,
  parameter int unsigned els_p        = 2
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    switch_2_blockValid_i,
  input  logic [ring_width_p-1:0] switch_2_blockData_i,
  output logic                    switch_2_blockRetry_o,
  output logic                    block_2_switchValid_o,
  output logic [ring_width_p-1:0] block_2_switchData_o,
  input  logic                    block_2_switchRetry_i,
  output logic                    v_o,
  output logic [ring_width_p-1:0] data_o,
  input  logic                    yumi_i,
  input  logic                    v_i,
  input  logic [ring_width_p-1:0] data_i,
  output logic                    ready_o
);

  localparam int unsigned PW = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int unsigned CW = $clog2(els_p + 1);
  localparam logic [CW-1:0] FULL = CW'(els_p);
  localparam logic [PW-1:0] LAST = PW'(els_p - 1);

  function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + PW'(1);
  endfunction

  // ---------------- rx path ----------------
  logic [ring_width_p-1:0] r_rx_mem [els_p];
  logic [PW-1:0]           r_rx_head, r_rx_tail;
  logic [CW-1:0]           r_rx_count;
  logic                    r_rx_retry;
  logic                    w_rx_accept, w_rx_pop;

  // Room is judged on registered occupancy only; a same-cycle pop never helps.
  assign w_rx_accept = switch_2_blockValid_i & (r_rx_count != FULL);
  assign w_rx_pop    = yumi_i & (r_rx_count != '0);

  // rx storage write
  always_ff @(posedge clk_i) begin
    if (w_rx_accept) r_rx_mem[r_rx_tail] <= switch_2_blockData_i;
  end

  // rx pointers, occupancy and registered retry
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_rx_head  <= '0;
      r_rx_tail  <= '0;
      r_rx_count <= '0;
      r_rx_retry <= 1'b0;
    end else begin
      if (w_rx_accept) r_rx_tail <= f_inc(r_rx_tail);
      if (w_rx_pop)    r_rx_head <= f_inc(r_rx_head);
      r_rx_count <= r_rx_count + CW'(w_rx_accept) - CW'(w_rx_pop);
      r_rx_retry <= switch_2_blockValid_i & (r_rx_count == FULL);
    end
  end

  assign v_o                   = ~reset_i & (r_rx_count != '0);
  assign data_o                = reset_i ? '0 : r_rx_mem[r_rx_head];
  assign switch_2_blockRetry_o = ~reset_i & r_rx_retry;

  // ---------------- tx path ----------------
  logic [ring_width_p-1:0] r_tx_mem [els_p];
  logic [PW-1:0]           r_tx_head, r_tx_tail;
  logic [CW-1:0]           r_tx_count;
  logic                    r_sent;
  logic                    r_live;
  logic                    w_retire, w_push;
  logic [CW-1:0]           w_eff;

  // A packet sent last cycle retires unless the switch retries it now; the
  // retired head is skipped immediately so the next packet goes out with no bubble.
  assign w_retire = r_sent & ~block_2_switchRetry_i;
  assign w_eff    = r_tx_count - CW'(w_retire);
  assign ready_o  = r_live & ~reset_i & (r_tx_count != FULL);
  assign w_push   = v_i & ready_o;

  assign block_2_switchValid_o = ~reset_i & (w_eff != '0);
  assign block_2_switchData_o  = reset_i  ? '0 :
                                 w_retire ? r_tx_mem[f_inc(r_tx_head)] :
                                            r_tx_mem[r_tx_head];

  // tx storage write
  always_ff @(posedge clk_i) begin
    if (w_push) r_tx_mem[r_tx_tail] <= data_i;
  end

  // tx pointers, occupancy, in-flight flag and post-reset ready gate
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_tx_head  <= '0;
      r_tx_tail  <= '0;
      r_tx_count <= '0;
      r_sent     <= 1'b0;
      r_live     <= 1'b0;
    end else begin
      if (w_retire) r_tx_head <= f_inc(r_tx_head);
      if (w_push)   r_tx_tail <= f_inc(r_tx_tail);
      r_tx_count <= r_tx_count - CW'(w_retire) + CW'(w_push);
      r_sent     <= block_2_switchValid_o;
      r_live     <= 1'b1;
    end
  end

`ifndef SYNTHESIS
  // A retry is only meaningful for a packet that was actually sent last cycle.
  a_retry_needs_send: assert property (@(posedge clk_i) disable iff (reset_i)
    block_2_switchRetry_i |-> r_sent);
`endif

endmodule

// File: tb/tb_bsg_murn_endpoint.sv
// Testbench for bsg_murn_endpoint: directed scenarios plus random traffic,
// checked every cycle against a queue-based reference model.
module tb_bsg_murn_endpoint;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        sw_v, sw_retry_o, bl_v, bl_retry;
  logic [79:0] sw_d, bl_d;
  logic        v_o, yumi_i, v_i, ready_o;
  logic [79:0] data_o, data_i;

  always #5 clk_i = ~clk_i;

  bsg_murn_endpoint #(.ring_width_p(80), .els_p(2)) dut (
    .clk_i                 (clk_i),
    .reset_i               (reset_i),
    .switch_2_blockValid_i (sw_v),
    .switch_2_blockData_i  (sw_d),
    .switch_2_blockRetry_o (sw_retry_o),
    .block_2_switchValid_o (bl_v),
    .block_2_switchData_o  (bl_d),
    .block_2_switchRetry_i (bl_retry),
    .v_o                   (v_o),
    .data_o                (data_o),
    .yumi_i                (yumi_i),
    .v_i                   (v_i),
    .data_i                (data_i),
    .ready_o               (ready_o)
  );

  int n_chk = 0;
  int n_bad = 0;

  // Reference model: packet queues plus a few flags.
  logic [79:0] rxq[$];
  logic [79:0] txq[$];
  bit          m_rx_retry;  // a switch packet was dropped last cycle
  bit          m_sent;      // txq front was on the link last cycle
  bit          m_live;      // at least one full cycle out of reset

  task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [79:0] rnd80();
    logic [95:0] t;
    t = {$urandom(), $urandom(), $urandom()};
    return t[79:0];
  endfunction

  // One clock cycle: drive, check, then advance the model at the clock edge.
  task automatic cyc(input bit rst, input bit sv, input logic [79:0] sd, input bit yw,
                     input bit cv, input logic [79:0] cd, input bit rw);
    bit          e_v, e_rr, e_tv, e_rdy, retire;
    logic [79:0] e_td;
    int          n;
    reset_i  = rst;
    sw_v     = sv;
    sw_d     = sd;
    yumi_i   = yw && (rxq.size() > 0) && !rst;
    v_i      = cv;
    data_i   = cd;
    bl_retry = rw && m_sent && !rst;
    #1;
    if (rst) begin
      chk("rst_v_o", v_o, 0);
      chk("rst_data_o", data_o, 0);
      chk("rst_retry_o", sw_retry_o, 0);
      chk("rst_valid_o", bl_v, 0);
      chk("rst_sw_data", bl_d, 0);
      chk("rst_ready_o", ready_o, 0);
      e_tv = 0; e_rdy = 0; retire = 0;
    end else begin
      e_v    = rxq.size() != 0;
      e_rr   = m_rx_retry;
      retire = m_sent && !bl_retry;
      e_tv   = (txq.size() - int'(retire)) > 0;
      e_td   = e_tv ? txq[retire ? 1 : 0] : '0;
      e_rdy  = m_live && (txq.size() < 2);
      chk("v_o", v_o, e_v);
      if (e_v) chk("data_o", data_o, rxq[0]);
      chk("retry_o", sw_retry_o, e_rr);
      chk("valid_o", bl_v, e_tv);
      if (e_tv) chk("sw_data", bl_d, e_td);
      chk("ready_o", ready_o, e_rdy);
    end
    @(posedge clk_i);
    if (rst) begin
      rxq.delete();
      txq.delete();
      m_rx_retry = 0;
      m_sent     = 0;
      m_live     = 0;
    end else begin
      n = rxq.size();
      m_rx_retry = sv && (n == 2);
      if (yumi_i) void'(rxq.pop_front());
      if (sv && n < 2) rxq.push_back(sd);
      if (retire) void'(txq.pop_front());
      m_sent = e_tv;
      if (cv && e_rdy) txq.push_back(cd);
      m_live = 1;
      if (rxq.size() > 2 || txq.size() > 2) begin
        n_chk++; n_bad++;
        $display("FAIL occupancy rx=%0d tx=%0d max=2", rxq.size(), txq.size());
      end
    end
    @(negedge clk_i);
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) cyc(0, 0, '0, 0, 0, '0, 0);
  endtask

  initial begin
    logic [79:0] a, b, c;
    reset_i = 1; sw_v = 0; sw_d = '0; yumi_i = 0; v_i = 0; data_i = '0; bl_retry = 0;
    m_rx_retry = 0; m_sent = 0; m_live = 0;
    @(negedge clk_i);
    cyc(1, 0, '0, 0, 0, '0, 0);
    cyc(1, 0, '0, 0, 0, '0, 0);
    idle(3);

    // rx single packet, consumed the cycle it appears
    cyc(0, 1, 80'h0123456789ABCDEF0011, 0, 0, '0, 0);
    cyc(0, 0, '0, 1, 0, '0, 0);
    idle(1);

    // rx full: third packet dropped, replay with yumi still dropped, then accepted
    a = rnd80(); b = rnd80(); c = rnd80();
    cyc(0, 1, a, 0, 0, '0, 0);
    cyc(0, 1, b, 0, 0, '0, 0);
    cyc(0, 1, c, 0, 0, '0, 0);
    cyc(0, 1, c, 1, 0, '0, 0);
    cyc(0, 1, c, 0, 0, '0, 0);
    cyc(0, 0, '0, 1, 0, '0, 0);
    cyc(0, 0, '0, 1, 0, '0, 0);
    cyc(0, 0, '0, 1, 0, '0, 0);
    idle(1);

    // tx streaming, no retries
    for (int k = 0; k < 8; k++) cyc(0, 0, '0, 0, 1, rnd80(), 0);
    idle(3);

    // tx retry: P0 retried three times, then P1
    cyc(0, 0, '0, 0, 1, 80'hAAAA_0000_0000_0000_0000, 0);
    cyc(0, 0, '0, 0, 1, 80'hBBBB_0000_0000_0000_0001, 0);
    cyc(0, 0, '0, 0, 0, '0, 1);
    cyc(0, 0, '0, 0, 0, '0, 1);
    cyc(0, 0, '0, 0, 0, '0, 1);
    idle(3);

    // simultaneous accept+pop and enqueue+retire, random retries
    for (int k = 0; k < 20; k++)
      cyc(0, 1, rnd80(), 1, 1, rnd80(), $urandom_range(3) == 0);
    idle(3);

    // reset with both FIFOs full and a retry pending
    for (int k = 0; k < 4; k++) cyc(0, 1, rnd80(), 0, 1, rnd80(), 1);
    cyc(1, 1, rnd80(), 0, 1, rnd80(), 0);
    cyc(0, 0, '0, 0, 1, rnd80(), 0);
    idle(4);

    // random traffic with occasional resets
    for (int k = 0; k < 400; k++)
      cyc($urandom_range(99) == 0, $urandom_range(9) < 7, rnd80(), $urandom_range(9) < 6,
          $urandom_range(9) < 7, rnd80(), $urandom_range(3) == 0);
    idle(4);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
